// File: rtl/pdec_wr_ctrl.sv
// -----------------------------------------------------------------------------
// pdec_wr_ctrl
//
// Write controller between the LLR update datapath and the banked LLR SRAM.
// Each of 8 decoding paths delivers a burst of result beats (4 lanes per beat)
// for the stage being produced. The controller packs beats into 8-lane SRAM
// words, routes each path to the bank named by its pointer vector and issues
// the writes. It signals completion with a one-cycle done pulse.
//
// Ports
//   clk                 clock, all state changes on the rising edge
//   rst                 asynchronous active-high reset
//   cur_stage           stage being produced, constant during a burst
//   path_valid          2 bits per path, bit 2i+1 set = path i inactive
//   uph2wrc_llr_ptr     per-path, per-stage 3-bit bank pointers
//   ulr2wrc_llr_st      per-path burst-start pulse (one cycle before beat 0)
//   ulr2wrc_llr_en      per-path beat valid
//   ulr2wrc_llr_data    per-path 4-lane beat data
//   wrc2sram_llr_wen    per-bank write enable
//   wrc2sram_llr_waddr  per-bank write address
//   wrc2sram_llr_wdata  per-bank 8-lane write data
//   wrc2sram_llr_wmask  per-bank lane mask (1 = lane written)
//   wrc2ctrl_wr_done    one-cycle pulse after the last write of a burst
//   wrc2ctrl_conflict   sticky bank-conflict flag
//   pdec_clk_en2        clock-gate enable for this block
// -----------------------------------------------------------------------------
module pdec_wr_ctrl #(
    parameter int WID_INN      = 10,
    parameter int WID_LLR_ADDR = 6,
    parameter int NUM_PTR      = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  cur_stage,
    input  logic [15:0]                 path_valid,
    input  logic [NUM_PTR*3*8-1:0]      uph2wrc_llr_ptr,
    input  logic [7:0]                  ulr2wrc_llr_st,
    input  logic [7:0]                  ulr2wrc_llr_en,
    input  logic [WID_INN*4*8-1:0]      ulr2wrc_llr_data,
    output logic [7:0]                  wrc2sram_llr_wen,
    output logic [WID_LLR_ADDR*8-1:0]   wrc2sram_llr_waddr,
    output logic [WID_INN*8*8-1:0]      wrc2sram_llr_wdata,
    output logic [63:0]                 wrc2sram_llr_wmask,
    output logic                        wrc2ctrl_wr_done,
    output logic                        wrc2ctrl_conflict,
    output logic                        pdec_clk_en2
);

    localparam int BW = 4 * WID_INN;   // one input beat (4 lanes)
    localparam int WW = 8 * WID_INN;   // one SRAM word (8 lanes)

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [7:0]          act_reg;
    logic [2:0]          bank_reg [8];
    logic [7:0][BW-1:0]  hold_reg;
    logic [15:0]         beat_cnt_reg;
    logic                last_wr_reg;
    logic                conflict_reg;

    logic [7:0]                 wen_reg,   wen_next;
    logic [WID_LLR_ADDR*8-1:0]  waddr_reg, waddr_next;
    logic [WW*8-1:0]            wdata_reg, wdata_next;
    logic [63:0]                wmask_reg, wmask_next;

    logic [2:0]          ptr_field [8];
    logic [7:0][BW-1:0]  din;
    logic [7:0][WW-1:0]  wdata_path;

    logic                any_st;
    logic                small_stage;
    logic [15:0]         beat_total;
    logic                beat_ok;
    logic                is_last;
    logic                fire;
    logic                conflict_hit;
    logic [WID_LLR_ADDR-1:0] wr_addr;
    logic [7:0]          wr_mask;

    assign any_st      = |ulr2wrc_llr_st;
    assign small_stage = (cur_stage <= 4'd2);
    assign beat_total  = small_stage ? 16'd1 : (16'd1 << (cur_stage - 4'd2));

    // A beat counts only inside a burst, before its final write, and never in
    // the same cycle as a (re)start pulse.
    assign beat_ok = (state_reg == ST_COLLECT) && !last_wr_reg && !any_st &&
                     (|(ulr2wrc_llr_en & act_reg));
    assign is_last = (beat_cnt_reg == beat_total - 16'd1);
    // Wide stages write on every odd beat (second half of a word); narrow
    // stages write on their single beat.
    assign fire    = beat_ok && (small_stage || beat_cnt_reg[0]);

    // Pointer field of the current stage for every path; stages beyond the
    // pointer vector select bank 0.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ptr_field[i] = 3'd0;
            for (int k = 0; k < NUM_PTR; k++) begin
                if (int'(cur_stage) == k) begin
                    ptr_field[i] = uph2wrc_llr_ptr[i*NUM_PTR*3 + k*3 +: 3];
                end
            end
        end
    end

    // Per-path word assembly: lane j of a word sits at bits [j*WID_INN +: WID_INN].
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_path
            assign din[gi] = ulr2wrc_llr_data[gi*BW +: BW];
            assign wdata_path[gi] =
                (cur_stage >= 4'd3) ? {din[gi], hold_reg[gi]} :
                (cur_stage == 4'd2) ? {din[gi], {BW{1'b0}}} :
                (cur_stage == 4'd1) ? {{BW{1'b0}}, din[gi][2*WID_INN-1:0], {2*WID_INN{1'b0}}} :
                                      {{6*WID_INN{1'b0}}, din[gi][WID_INN-1:0], {WID_INN{1'b0}}};
        end
    endgenerate

    // Address and mask are shared by all paths of a burst.
    always_comb begin
        wr_addr = '0;
        wr_mask = 8'hFF;
        case (cur_stage)
            4'd0:    wr_mask = 8'h02;
            4'd1:    wr_mask = 8'h0C;
            4'd2:    wr_mask = 8'hF0;
            default: wr_addr = (WID_LLR_ADDR'(1) << (cur_stage - 4'd3)) +
                               WID_LLR_ADDR'(beat_cnt_reg >> 1);
        endcase
    end

    // Bank routing. Paths are scanned from high to low index so the lowest
    // active path targeting a bank is the one that ends up driving it.
    always_comb begin
        wen_next   = '0;
        waddr_next = '0;
        wdata_next = '0;
        wmask_next = '0;
        for (int b = 0; b < 8; b++) begin
            for (int i = 7; i >= 0; i--) begin
                if (fire && act_reg[i] && (bank_reg[i] == 3'(b))) begin
                    wen_next[b]                                 = 1'b1;
                    waddr_next[b*WID_LLR_ADDR +: WID_LLR_ADDR]  = wr_addr;
                    wdata_next[b*WW +: WW]                      = wdata_path[i];
                    wmask_next[b*8 +: 8]                        = wr_mask;
                end
            end
        end
    end

    always_comb begin
        conflict_hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                if (act_reg[i] && act_reg[j] && (bank_reg[i] == bank_reg[j])) begin
                    conflict_hit = 1'b1;
                end
            end
        end
        conflict_hit = conflict_hit && fire;
    end

    // A start pulse always (re)starts collection, which also aborts a burst
    // in progress without writing its partial word.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (any_st) state_next = ST_COLLECT;
            ST_COLLECT: begin
                if (any_st)           state_next = ST_COLLECT;
                else if (last_wr_reg) state_next = ST_DONE;
            end
            ST_DONE:    state_next = any_st ? ST_COLLECT : ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            act_reg      <= '0;
            hold_reg     <= '0;
            beat_cnt_reg <= '0;
            last_wr_reg  <= 1'b0;
            conflict_reg <= 1'b0;
            wen_reg      <= '0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
            for (int i = 0; i < 8; i++) begin
                bank_reg[i] <= 3'd0;
            end
        end else begin
            state_reg <= state_next;
            if (any_st) begin
                beat_cnt_reg <= '0;
                for (int i = 0; i < 8; i++) begin
                    act_reg[i]  <= ~path_valid[2*i+1];
                    bank_reg[i] <= ptr_field[i];
                end
            end else if (beat_ok) begin
                beat_cnt_reg <= beat_cnt_reg + 16'd1;
            end
            // First half of a wide word waits here for its odd partner beat.
            if (beat_ok && !small_stage && !beat_cnt_reg[0]) begin
                hold_reg <= din;
            end
            last_wr_reg  <= fire && is_last;
            conflict_reg <= conflict_reg | conflict_hit;
            wen_reg      <= wen_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            wmask_reg    <= wmask_next;
        end
    end

    assign wrc2sram_llr_wen   = wen_reg;
    assign wrc2sram_llr_waddr = waddr_reg;
    assign wrc2sram_llr_wdata = wdata_reg;
    assign wrc2sram_llr_wmask = wmask_reg;
    assign wrc2ctrl_wr_done   = (state_reg == ST_DONE);
    assign wrc2ctrl_conflict  = conflict_reg;
    assign pdec_clk_en2       = any_st | (|ulr2wrc_llr_en) | (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pdec_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pdec_wr_ctrl
//
// Directed bench for pdec_wr_ctrl: a vector table of single-beat bursts
// (stages 0..2, routing, ownership, conflict) plus hand-written sequences for
// a multi-beat burst, an aborted burst and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_pdec_wr_ctrl;

    localparam int WI = 10;
    localparam int WA = 6;
    localparam int NP = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           cur_stage;
    logic [15:0]          path_valid;
    logic [NP*3*8-1:0]    ptr;
    logic [7:0]           llr_st;
    logic [7:0]           llr_en;
    logic [WI*4*8-1:0]    llr_data;
    logic [7:0]           wen;
    logic [WA*8-1:0]      waddr;
    logic [WI*8*8-1:0]    wdata;
    logic [63:0]          wmask;
    logic                 wr_done;
    logic                 conflict;
    logic                 clk_en2;

    int total = 0;
    int bad   = 0;

    pdec_wr_ctrl #(.WID_INN(WI), .WID_LLR_ADDR(WA), .NUM_PTR(NP)) dut (
        .clk                (clk),
        .rst                (rst),
        .cur_stage          (cur_stage),
        .path_valid         (path_valid),
        .uph2wrc_llr_ptr    (ptr),
        .ulr2wrc_llr_st     (llr_st),
        .ulr2wrc_llr_en     (llr_en),
        .ulr2wrc_llr_data   (llr_data),
        .wrc2sram_llr_wen   (wen),
        .wrc2sram_llr_waddr (waddr),
        .wrc2sram_llr_wdata (wdata),
        .wrc2sram_llr_wmask (wmask),
        .wrc2ctrl_wr_done   (wr_done),
        .wrc2ctrl_conflict  (conflict),
        .pdec_clk_en2       (clk_en2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       stage;
        logic [7:0]       act;
        logic [7:0][2:0]  bank;
        logic [7:0]       exp_wen;
        logic [7:0]       exp_mask;
        logic [7:0][2:0]  exp_owner;
        logic             exp_conf;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane value for path p, beat b, lane l (never zero).
    function automatic logic [9:0] lv(input int p, input int b, input int l);
        return 10'(p*64 + b*8 + l + 1);
    endfunction

    function automatic logic [79:0] exp_small(input int k, input int p);
        logic [79:0] r;
        r = '0;
        if (k == 2) begin
            for (int l = 0; l < 4; l++) r[(4+l)*WI +: WI] = lv(p, 0, l);
        end else if (k == 1) begin
            r[2*WI +: WI] = lv(p, 0, 0);
            r[3*WI +: WI] = lv(p, 0, 1);
        end else begin
            r[1*WI +: WI] = lv(p, 0, 0);
        end
        return r;
    endfunction

    function automatic logic [79:0] exp_word(input int p, input int n);
        logic [79:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l*WI +: WI]     = lv(p, 2*n, l);
            r[(4+l)*WI +: WI] = lv(p, 2*n + 1, l);
        end
        return r;
    endfunction

    task automatic setup(input logic [3:0] stage, input logic [7:0] act, input logic [7:0][2:0] bank);
        cur_stage = stage;
        for (int i = 0; i < 8; i++) begin
            path_valid[2*i+1] = ~act[i];
            path_valid[2*i]   = act[i];
            for (int s = 0; s < NP; s++) begin
                ptr[i*NP*3 + s*3 +: 3] = (s == int'(stage)) ? bank[i] : ~bank[i];
            end
        end
    endtask

    task automatic drive_beat(input int b);
        for (int p = 0; p < 8; p++)
            for (int l = 0; l < 4; l++)
                llr_data[p*4*WI + l*WI +: WI] = lv(p, b, l);
    endtask

    task automatic start_burst();
        llr_st = 8'h01;
        tick();
        llr_st = 8'h00;
    endtask

    initial begin
        int wcnt;
        int dcnt;
        int viol;
        logic [WA-1:0] seen_addr;
        logic [79:0]   seen_data;

        rst = 1'b1;
        cur_stage = '0; path_valid = '0; ptr = '0;
        llr_st = '0; llr_en = '0; llr_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_wen",      wen,      '0);
        chk("rst_waddr",    waddr,    '0);
        chk("rst_wdata",    wdata,    '0);
        chk("rst_wmask",    wmask,    '0);
        chk("rst_done",     wr_done,  '0);
        chk("rst_conflict", conflict, '0);
        chk("rst_clk_en2",  clk_en2,  '0);

        // Beats while idle are ignored but still request the clock.
        llr_en = 8'hFF;
        drive_beat(0);
        #1;
        chk("idle_clk_en2", clk_en2, 1'b1);
        tick();
        chk("idle_en_wen", wen, '0);
        llr_en = 8'h00;
        tick();

        // stage, active paths, bank per path [7..0], wen, mask, owner per bank [7..0], conflict
        vecs[0] = '{4'd1, 8'h04, {3'd3,3'd2,3'd1,3'd0,3'd7,3'd6,3'd5,3'd4}, 8'h40, 8'h0C,
                    {3'd0,3'd2,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 1'b0};
        vecs[1] = '{4'd0, 8'hFF, {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, 8'hFF, 8'h02,
                    {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0}, 1'b0};
        vecs[2] = '{4'd2, 8'h09, {3'd0,3'd0,3'd0,3'd0,3'd1,3'd1,3'd7,3'd7}, 8'h82, 8'hF0,
                    {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd3,3'd0}, 1'b0};
        vecs[3] = '{4'd2, 8'h12, {3'd5,3'd5,3'd5,3'd2,3'd5,3'd5,3'd2,3'd2}, 8'h04, 8'hF0,
                    {3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd0,3'd0}, 1'b1};
        vecs[4] = '{4'd0, 8'h20, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0}, 8'h01, 8'h02,
                    {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd5}, 1'b1};

        for (int v = 0; v < 5; v++) begin
            setup(vecs[v].stage, vecs[v].act, vecs[v].bank);
            start_burst();
            llr_en = 8'hFF;
            drive_beat(0);
            tick();
            llr_en = 8'h00;
            chk($sformatf("v%0d_wen", v), wen, vecs[v].exp_wen);
            chk($sformatf("v%0d_done_early", v), wr_done, 1'b0);
            for (int b = 0; b < 8; b++) begin
                if (vecs[v].exp_wen[b]) begin
                    chk($sformatf("v%0d_b%0d_addr", v, b), waddr[b*WA +: WA], '0);
                    chk($sformatf("v%0d_b%0d_mask", v, b), wmask[b*8 +: 8], vecs[v].exp_mask);
                    chk($sformatf("v%0d_b%0d_data", v, b), wdata[b*80 +: 80],
                        exp_small(int'(vecs[v].stage), int'(vecs[v].exp_owner[b])));
                end else begin
                    chk($sformatf("v%0d_b%0d_idle", v, b),
                        {waddr[b*WA +: WA], wmask[b*8 +: 8], wdata[b*80 +: 80]}, '0);
                end
            end
            tick();
            chk($sformatf("v%0d_done", v), wr_done, 1'b1);
            chk($sformatf("v%0d_wen_after", v), wen, '0);
            chk($sformatf("v%0d_conflict", v), conflict, vecs[v].exp_conf);
            tick();
            chk($sformatf("v%0d_done_gone", v), wr_done, 1'b0);
            $display("vector %0d stage=%0d act=%02h wen=%02h conflict=%0b",
                     v, vecs[v].stage, vecs[v].act, vecs[v].exp_wen, conflict);
        end

        // Stage 4, paths 0/1 on banks 3/5, 4 beats -> two words at addr 2 and 3.
        setup(4'd4, 8'h03, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd5,3'd3});
        start_burst();
        for (int bt = 0; bt < 4; bt++) begin
            llr_en = 8'h03;
            drive_beat(bt);
            tick();
            chk($sformatf("k4_beat%0d_done", bt), wr_done, 1'b0);
            if (bt % 2 == 1) begin
                chk($sformatf("k4_w%0d_wen", bt/2), wen, 8'h28);
                chk($sformatf("k4_w%0d_addr3", bt/2), waddr[3*WA +: WA], WA'(2 + bt/2));
                chk($sformatf("k4_w%0d_addr5", bt/2), waddr[5*WA +: WA], WA'(2 + bt/2));
                chk($sformatf("k4_w%0d_mask3", bt/2), wmask[3*8 +: 8], 8'hFF);
                chk($sformatf("k4_w%0d_mask5", bt/2), wmask[5*8 +: 8], 8'hFF);
                chk($sformatf("k4_w%0d_data3", bt/2), wdata[3*80 +: 80], exp_word(0, bt/2));
                chk($sformatf("k4_w%0d_data5", bt/2), wdata[5*80 +: 80], exp_word(1, bt/2));
            end else begin
                chk($sformatf("k4_beat%0d_nowr", bt), wen, '0);
            end
        end
        llr_en = 8'h00;
        tick();
        chk("k4_done", wr_done, 1'b1);
        chk("k4_done_wen", wen, '0);
        tick();
        chk("k4_done_gone", wr_done, 1'b0);
        $display("burst stage=4 paths=0,1 banks=3,5 writes=2");

        // Stage 3, restart after one beat, then a full burst -> one write to addr 1.
        setup(4'd3, 8'h01, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4});
        wcnt = 0; dcnt = 0; seen_addr = '0; seen_data = '0;
        start_burst();
        llr_en = 8'h01; drive_beat(7);
        tick();
        if (wen != 0) wcnt++;
        if (wr_done) dcnt++;
        llr_en = 8'h00; llr_st = 8'h01;
        tick();
        llr_st = 8'h00;
        if (wen != 0) wcnt++;
        if (wr_done) dcnt++;
        for (int c = 0; c < 6; c++) begin
            llr_en = (c < 2) ? 8'h01 : 8'h00;
            drive_beat(c);
            tick();
            if (wen != 0) begin
                wcnt++;
                seen_addr = waddr[4*WA +: WA];
                seen_data = wdata[4*80 +: 80];
            end
            if (wr_done) dcnt++;
        end
        chk("abort_writes", 32'(wcnt), 32'd1);
        chk("abort_dones",  32'(dcnt), 32'd1);
        chk("abort_addr",   seen_addr, WA'(1));
        chk("abort_data",   seen_data, exp_word(0, 0));
        $display("burst stage=3 aborted once writes=%0d dones=%0d", wcnt, dcnt);

        // Stage 5, reset during beat 2: outputs clear at once, nothing follows.
        setup(4'd5, 8'h01, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd1});
        start_burst();
        for (int bt = 0; bt < 2; bt++) begin
            llr_en = 8'h01; drive_beat(bt);
            tick();
        end
        chk("k5_pre_rst_wen", wen, 8'h02);
        chk("k5_pre_rst_addr", waddr[1*WA +: WA], WA'(4));
        drive_beat(2);
        #2;
        rst = 1'b1;
        #1;
        chk("k5_rst_wen",      wen,      '0);
        chk("k5_rst_waddr",    waddr,    '0);
        chk("k5_rst_wdata",    wdata,    '0);
        chk("k5_rst_wmask",    wmask,    '0);
        chk("k5_rst_done",     wr_done,  '0);
        chk("k5_rst_conflict", conflict, '0);
        tick();
        rst = 1'b0;
        viol = 0;
        for (int bt = 3; bt < 10; bt++) begin
            drive_beat(bt);
            tick();
            if (wen != 0 || wr_done) viol++;
        end
        llr_en = 8'h00;
        chk("k5_post_rst_quiet", 32'(viol), 32'd0);
        $display("burst stage=5 reset mid-burst post-release activity=%0d", viol);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdec_wr_ctrl.md
PDEC_WR_CTRL -- requirements
Module: pdec_wr_ctrl

Interface
REQ-001 WID_INN, default 10, width of one inner LLR lane.
REQ-002 WID_LLR_ADDR, default 6, LLR SRAM bank address width.
REQ-003 NUM_PTR, default 9, number of stages per pointer vector, 3 bits each.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cur_stage  in  4  stage being produced; held constant for the whole burst.
REQ-007 path_valid  in  16  2 bits per path; bit 2i+1 set marks path i invalid.
REQ-008 uph2wrc_llr_ptr  in  NUM_PTR*3*8  per-path bank pointers; path i stage k bank = bits [i*NUM_PTR*3 + k*3 +: 3].
REQ-009 ulr2wrc_llr_st  in  8  per-path burst-start pulse, one cycle before the first beat.
REQ-010 ulr2wrc_llr_en  in  8  per-path result beat valid.
REQ-011 ulr2wrc_llr_data  in  WID_INN*4*8  per path: 4 result lanes per beat, at bits [i*WID_INN*4 +: WID_INN*4].
REQ-012 wrc2sram_llr_wen  out  8  per-bank write enable.
REQ-013 wrc2sram_llr_waddr  out  WID_LLR_ADDR*8  per-bank write address.
REQ-014 wrc2sram_llr_wdata  out  WID_INN*8*8  per-bank write data, 8 lanes.
REQ-015 wrc2sram_llr_wmask  out  8*8  per-bank lane write mask; 1 = lane written.
REQ-016 wrc2ctrl_wr_done  out  1  one-cycle pulse after the last write of a burst.
REQ-017 wrc2ctrl_conflict  out  1  sticky bank-conflict flag.
REQ-018 pdec_clk_en2  out  1  ICG enable for this block.

Function
REQ-019 Active path i: path_valid[2i+1]==0; inactive paths produce no writes and do not affect done.
REQ-020 Stage k storage layout, k>=3: base address 2^(k-3), 2^(k-3) words, all 8 lanes per word.
REQ-021 Stage k storage layout, k<=2: address 0, lanes [2^k, 2^(k+1)) only.
REQ-022 State machine: IDLE -> COLLECT on any ulr2wrc_llr_st; COLLECT -> DONE after the final write is issued; DONE -> IDLE after one cycle, asserting wr_done.
REQ-023 Beat count per burst: 2^(cur_stage-2) for cur_stage>=3; exactly 1 for cur_stage<=2.
REQ-024 A common beat counter and packing phase are cleared on llr_st and advance on any active llr_en; active paths receive beats in lockstep.
REQ-025 Packing for k>=3: even beat -> lanes 0..3 of a per-path holding register; odd beat -> lanes 4..7.
REQ-026 Write timing for k>=3: the write is issued the cycle after the odd beat; write n (n from 0) goes to address 2^(k-3)+n.
REQ-027 Write for k=2: input lanes 0..3 -> lanes 4..7, mask 0xF0.
REQ-028 Write for k=1: input lanes 0..1 -> lanes 2..3, mask 0x0C.
REQ-029 Write for k=0: input lane 0 -> lane 1, mask 0x02.
REQ-030 For k<=2, the write is issued the cycle after the single beat; unused lanes in wdata are 0.
REQ-031 Bank for path i = pointer field for stage cur_stage, latched on llr_st.
REQ-032 Bank outputs: wen[b], waddr, wdata and wmask are driven from the owning path; all bank outputs are 0 when wen[b]==0.
REQ-033 Bank conflict: if two active paths map to one bank, the lowest path index wins and wrc2ctrl_conflict is set until reset.
REQ-034 llr_st received in COLLECT aborts the current burst: no write for a partial pair, counters restart, no done pulse for the aborted burst.
REQ-035 llr_en while IDLE is ignored.
REQ-036 Address arithmetic is WID_LLR_ADDR wide and unsigned; it never wraps for cur_stage <= WID_LLR_ADDR+2.
REQ-037 pdec_clk_en2 = any llr_st | any llr_en | state != IDLE.

Reset
REQ-038 On rst: state IDLE; counters, holding registers and latched banks cleared; wen=0, waddr=0, wdata=0, wmask=0, wr_done=0, conflict=0.
REQ-039 Reset asserted mid-burst discards the burst; no write or done pulse follows the reset release.

Verification
REQ-040 k=4, paths 0/1 active on banks 3/5, 4 beats -> 2 writes each: addr 2 then 3, mask 0xFF; wr_done 1 cycle after the 2nd write.
REQ-041 k=1, path 2 on bank 6, one beat with lanes {A,B} -> bank 6 addr 0, wdata lanes 2,3 = A,B, mask 0x0C.
REQ-042 k=0, all paths active, banks 0..7 -> 8 simultaneous writes, addr 0, mask 0x02.
REQ-043 Paths 1 and 4 both on bank 2 -> only path 1 data written to bank 2; conflict=1 and held after the next burst.
REQ-044 k=3, llr_st again after 1 beat, then 2 full beats -> exactly one write to addr 1, one done pulse.
REQ-045 rst during beat 2 of a k=5 burst -> all outputs 0 immediately; no write or done after release.
